int_ack_master: RTL

- CPU-side interrupt acknowledge sequencer: the processor end of the INT/INTA protocol whose controller end is driven by the interrupt request register.
- Synchronises the controller's INT output and, when the core has interrupts enabled, issues the 8086-style two-pulse INTA_n sequence.
- Captures the 8-bit vector from the data bus during the second pulse and hands it to the core over a valid/ack handshake.

---
 rtl/int_ack_master.sv | 105 ++++++++++
 1 files changed

// File: rtl/int_ack_master.sv
// int_ack_master: CPU-side INT/INTA sequencer issuing a two-pulse INTA_n and capturing the vector.
// Optional macro INTA_LOCK_EN drives lock_n low from the first INTA_n fall to the end of pulse 2.
module int_ack_master #(
    parameter int PULSE_W = 2,
    parameter int GAP_W   = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       INT,
    input  logic       int_enable,
    input  logic [7:0] data_in,
    output logic       INTA_n,
    output logic [7:0] vector,
    output logic       vector_valid,
    input  logic       vec_ack,
    output logic       busy,
    output logic       lock_n
);
    typedef enum logic [2:0] {IDLE, P1, G1, P2, HOLD, COOL} state_t;

    localparam logic [3:0] PLOAD = 4'(PULSE_W - 1);
    localparam logic [3:0] GLOAD = 4'(GAP_W - 1);

    state_t     state, state_d;
    logic [3:0] cnt, cnt_d;
    logic       sync1, int_s;
    logic       inta_d, valid_d;
    logic [7:0] vector_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            sync1        <= 1'b0;
            int_s        <= 1'b0;
            INTA_n       <= 1'b1;
            vector       <= 8'h00;
            vector_valid <= 1'b0;
        end else begin
            state        <= state_d;
            cnt          <= cnt_d;
            sync1        <= INT;
            int_s        <= sync1;
            INTA_n       <= inta_d;
            vector       <= vector_d;
            vector_valid <= valid_d;
        end
    end

    // Outputs are computed one edge ahead so INTA_n changes on the same edge as the state.
    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        inta_d   = INTA_n;
        vector_d = vector;
        valid_d  = vector_valid;
        case (state)
            IDLE: if (int_s && int_enable) begin
                state_d = P1;
                cnt_d   = PLOAD;
                inta_d  = 1'b0;
            end
            P1: if (cnt == 4'd0) begin
                state_d = G1;
                cnt_d   = GLOAD;
                inta_d  = 1'b1;
            end else cnt_d = cnt - 4'd1;
            G1: if (cnt == 4'd0) begin
                state_d = P2;
                cnt_d   = PLOAD;
                inta_d  = 1'b0;
            end else cnt_d = cnt - 4'd1;
            P2: if (cnt == 4'd0) begin
                state_d  = HOLD;
                inta_d   = 1'b1;
                vector_d = data_in;
                valid_d  = 1'b1;
            end else cnt_d = cnt - 4'd1;
            HOLD: if (vec_ack) begin
                state_d = COOL;
                cnt_d   = GLOAD;
                valid_d = 1'b0;
            end
            COOL: if (cnt == 4'd0) state_d = IDLE;
                  else cnt_d = cnt - 4'd1;
            default: state_d = IDLE;
        endcase
    end

    assign busy = state != IDLE;

`ifdef INTA_LOCK_EN
    always_ff @(posedge clk) begin
        if (!rst_n)
            lock_n <= 1'b1;
        else if (state == IDLE && state_d == P1)
            lock_n <= 1'b0;
        else if (state == P2 && state_d == HOLD)
            lock_n <= 1'b1;
    end
`else
    assign lock_n = 1'b1;
`endif

endmodule
